// File: rtl/hazard_unit.sv
// ID-stage data-hazard resolver for the 5-stage predicated pipeline.
// Compares ID source registers (Rs/Rt) against the destinations of the
// instructions in EX/MEM/WB and produces:
//   ForwardA/ForwardB : operand-bus mux selects (00 regfile, 01 EX, 10 MEM, 11 WB)
//   Stall             : load-use stall request (freezes PC/IR, bubbles ID/EX)
//   stall_count       : registered, saturating count of stall cycles
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   Rs, Rt                           ID source registers
//   Rd_EX, Rd_MEM, Rd_WB             destination registers per stage
//   RegWrite_EX/MEM/WB               stage writes a register
//   MemRead_EX                       EX instruction is a load
//   RPzero_EX/MEM/WB                 stage instruction predicated off
//   ForwardA, ForwardB, Stall        combinational hazard outputs
//   stall_count                      registered stall-cycle counter
module hazard_unit #(
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    Rs,
  input  logic [AW-1:0]    Rt,
  input  logic [AW-1:0]    Rd_EX,
  input  logic [AW-1:0]    Rd_MEM,
  input  logic [AW-1:0]    Rd_WB,
  input  logic             RegWrite_EX,
  input  logic             RegWrite_MEM,
  input  logic             RegWrite_WB,
  input  logic             MemRead_EX,
  input  logic             RPzero_EX,
  input  logic             RPzero_MEM,
  input  logic             RPzero_WB,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  // R0 and R30 are hardwired and never act as a hazard source.
  localparam logic [AW-1:0] R_ZERO = AW'(0);
  localparam logic [AW-1:0] R_HARD = AW'(30);

  logic w_ex;
  logic w_mem;
  logic w_wb;
  logic ex_fwd_ok;

  // Effective (architecturally visible) write per stage.
  always_comb begin
    w_ex  = RegWrite_EX  & ~RPzero_EX  & (Rd_EX  != R_ZERO) & (Rd_EX  != R_HARD);
    w_mem = RegWrite_MEM & ~RPzero_MEM & (Rd_MEM != R_ZERO) & (Rd_MEM != R_HARD);
    w_wb  = RegWrite_WB  & ~RPzero_WB  & (Rd_WB  != R_ZERO) & (Rd_WB  != R_HARD);
    // A load in EX has no data yet, so it can never be the EX forward source.
    ex_fwd_ok = w_ex & ~MemRead_EX;
  end

  // Forward selects, youngest producer wins.
  always_comb begin
    ForwardA = SEL_RF;
    ForwardB = SEL_RF;

    if (ex_fwd_ok && (Rd_EX == Rs)) begin
      ForwardA = SEL_EX;
    end else if (w_mem && (Rd_MEM == Rs)) begin
      ForwardA = SEL_MEM;
    end else if (w_wb && (Rd_WB == Rs)) begin
      ForwardA = SEL_WB;
    end

    if (ex_fwd_ok && (Rd_EX == Rt)) begin
      ForwardB = SEL_EX;
    end else if (w_mem && (Rd_MEM == Rt)) begin
      ForwardB = SEL_MEM;
    end else if (w_wb && (Rd_WB == Rt)) begin
      ForwardB = SEL_WB;
    end
  end

  // Load-use stall: one cycle, after which the load sits in MEM and forwards.
  always_comb begin
    Stall = MemRead_EX & w_ex & ((Rd_EX == Rs) | (Rd_EX == Rt));
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (Stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus a random
// sweep, with expectations queued in a scoreboard and compared on drain.
module tb_hazard_unit;

  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] Rs, Rt, Rd_EX, Rd_MEM, Rd_WB;
  logic          RegWrite_EX, RegWrite_MEM, RegWrite_WB;
  logic          MemRead_EX;
  logic          RPzero_EX, RPzero_MEM, RPzero_WB;
  logic [1:0]    ForwardA, ForwardB;
  logic          Stall;
  logic [15:0]   stall_count;
  logic [1:0]    ForwardA2, ForwardB2;
  logic          Stall2;
  logic [1:0]    stall_count2;

  int n_chk = 0;
  int n_err = 0;

  int unsigned exp_cnt  = 0;
  int unsigned exp_cnt2 = 0;

  typedef struct {
    string       tag;
    int          kind;   // 0 FA, 1 FB, 2 Stall, 3 count, 4 count (CNT_W=2)
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  hazard_unit #(.AW(AW), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .Rs(Rs), .Rt(Rt),
    .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .MemRead_EX(MemRead_EX),
    .RPzero_EX(RPzero_EX), .RPzero_MEM(RPzero_MEM), .RPzero_WB(RPzero_WB),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall),
    .stall_count(stall_count)
  );

  hazard_unit #(.AW(AW), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .Rs(Rs), .Rt(Rt),
    .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .MemRead_EX(MemRead_EX),
    .RPzero_EX(RPzero_EX), .RPzero_MEM(RPzero_MEM), .RPzero_WB(RPzero_WB),
    .ForwardA(ForwardA2), .ForwardB(ForwardB2), .Stall(Stall2),
    .stall_count(stall_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of the hazard rules.
  function automatic logic weff(input logic rw, input logic rp, input logic [AW-1:0] rd);
    return rw & ~rp & (rd != 5'd0) & (rd != 5'd30);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
    if (weff(RegWrite_EX, RPzero_EX, Rd_EX) && !MemRead_EX && Rd_EX == src) return 2'b01;
    if (weff(RegWrite_MEM, RPzero_MEM, Rd_MEM) && Rd_MEM == src)             return 2'b10;
    if (weff(RegWrite_WB, RPzero_WB, Rd_WB) && Rd_WB == src)                 return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic ref_stall();
    return MemRead_EX & weff(RegWrite_EX, RPzero_EX, Rd_EX) & ((Rd_EX == Rs) | (Rd_EX == Rt));
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    sb_t it;
    it.tag = tag; it.kind = kind; it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic drain();
    sb_t it;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.kind)
        0:       obs = 32'(ForwardA);
        1:       obs = 32'(ForwardB);
        2:       obs = 32'(Stall);
        3:       obs = 32'(stall_count);
        default: obs = 32'(stall_count2);
      endcase
      check(it.tag, obs, it.exp);
    end
  endtask

  task automatic expect_comb(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                             input logic st);
    push({tag, "_fa"}, 0, 32'(fa));
    push({tag, "_fb"}, 1, 32'(fb));
    push({tag, "_st"}, 2, 32'(st));
    #1;
    drain();
  endtask

  task automatic check_cnt(input string tag);
    push({tag, "_cnt"},  3, exp_cnt);
    push({tag, "_cnt2"}, 4, exp_cnt2);
    drain();
  endtask

  // One clock edge; the model counter follows the expected stall.
  task automatic tick();
    @(posedge clk);
    if (ref_stall()) begin
      if (exp_cnt  < 32'hFFFF) exp_cnt++;
      if (exp_cnt2 < 3)        exp_cnt2++;
    end
    #2;
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    exp_cnt  = 0;
    exp_cnt2 = 0;
    check_cnt(tag);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic clr();
    Rs = '0; Rt = '0; Rd_EX = '0; Rd_MEM = '0; Rd_WB = '0;
    RegWrite_EX = 1'b0; RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;
    MemRead_EX = 1'b0;
    RPzero_EX = 1'b0; RPzero_MEM = 1'b0; RPzero_WB = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_reg();
    case ($urandom_range(0, 4))
      0:       return 5'd0;
      1:       return 5'd30;
      2:       return 5'd1;
      3:       return 5'd2;
      default: return 5'd3;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    #1;
    check_cnt("reset");
    #1;
    rst_n = 1'b1;
    tick();

    // EX forward on A only
    clr(); Rs = 5'd2; Rd_EX = 5'd2; RegWrite_EX = 1'b1;
    expect_comb("t1_ex", 2'b01, 2'b00, 1'b0);

    // EX > MEM > WB priority
    clr(); Rs = 5'd5; Rt = 5'd5; Rd_EX = 5'd5; Rd_MEM = 5'd5; Rd_WB = 5'd5;
    RegWrite_EX = 1'b1; RegWrite_MEM = 1'b1; RegWrite_WB = 1'b1;
    expect_comb("t2_ex", 2'b01, 2'b01, 1'b0);
    RegWrite_EX = 1'b0;
    expect_comb("t2_mem", 2'b10, 2'b10, 1'b0);
    RegWrite_MEM = 1'b0;
    expect_comb("t2_wb", 2'b11, 2'b11, 1'b0);
    tick();
    check_cnt("t2");

    // Load-use on Rt, then the load moves to MEM
    clr(); Rt = 5'd7; Rd_EX = 5'd7; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    expect_comb("t3_stall", 2'b00, 2'b00, 1'b1);
    tick();
    clr(); Rt = 5'd7; Rd_MEM = 5'd7; RegWrite_MEM = 1'b1;
    expect_comb("t3_mem", 2'b00, 2'b10, 1'b0);
    check_cnt("t3");

    // Load in EX falls through to an older MEM producer while stalling
    clr(); Rs = 5'd9; Rd_EX = 5'd9; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    Rd_MEM = 5'd9; RegWrite_MEM = 1'b1;
    expect_comb("ld_fall", 2'b10, 2'b00, 1'b1);
    tick();
    check_cnt("ld_fall");

    // Predicated-off producers
    clr(); Rs = 5'd3; Rd_MEM = 5'd3; RegWrite_MEM = 1'b1; RPzero_MEM = 1'b1;
    expect_comb("t4_mem_pz", 2'b00, 2'b00, 1'b0);
    Rd_EX = 5'd3; RegWrite_EX = 1'b1; MemRead_EX = 1'b1; RPzero_EX = 1'b1;
    expect_comb("t4_ld_pz", 2'b00, 2'b00, 1'b0);
    tick();
    check_cnt("t4");

    // Hardwired registers
    clr(); Rd_EX = 5'd0; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    expect_comb("t5_r0", 2'b00, 2'b00, 1'b0);
    clr(); Rs = 5'd30; Rd_WB = 5'd30; RegWrite_WB = 1'b1;
    expect_comb("t5_r30", 2'b00, 2'b00, 1'b0);

    // Stall counting and saturation
    reset_pulse("t6_rst0");
    clr(); Rs = 5'd4; Rd_EX = 5'd4; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    expect_comb("t6_st", 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check_cnt("t6_five");
    tick();
    check_cnt("t6_six");
    reset_pulse("t6_rst1");

    // Random sweep against the model
    for (int i = 0; i < 60; i++) begin
      Rs = rnd_reg(); Rt = rnd_reg();
      Rd_EX = rnd_reg(); Rd_MEM = rnd_reg(); Rd_WB = rnd_reg();
      RegWrite_EX  = 1'($urandom_range(0, 1));
      RegWrite_MEM = 1'($urandom_range(0, 1));
      RegWrite_WB  = 1'($urandom_range(0, 1));
      MemRead_EX   = 1'($urandom_range(0, 1));
      RPzero_EX    = ($urandom_range(0, 3) == 0);
      RPzero_MEM   = ($urandom_range(0, 3) == 0);
      RPzero_WB    = ($urandom_range(0, 3) == 0);
      expect_comb("rnd", ref_fwd(Rs), ref_fwd(Rt), ref_stall());
      tick();
      check_cnt("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
